// File: rtl/fsb_pkg.sv
// Shared types and constants for the front-side-bus initiator slice.
package fsb_pkg;

  localparam int ADDR_W      = 23;
  localparam int DATA_W      = 16;
  localparam int TIMEOUT_MIN = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ASSERT,
    ST_DSW,
    ST_WAIT,
    ST_DATA,
    ST_NEGATE,
    ST_RECOVER
  } fsb_state_e;

endpackage

// File: rtl/fsb_sync.sv
// Two-flop synchronizer for asynchronous responder handshakes.
module fsb_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/fsb_initiator.sv
// 68000-style bus master: runs one word/byte transfer per request with a
// watchdog that aborts unanswered cycles and bounds the recovery wait.
module fsb_initiator
  import fsb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              FCLK,
  input  logic              Reset,
  input  logic              Req,
  input  logic              ReqRnW,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [1:0]        ReqBE,
  input  logic [DATA_W-1:0] ReqWrData,
  output logic              Busy,
  output logic              Ack,
  output logic              Err,
  output logic [DATA_W-1:0] RdData,
  output logic [ADDR_W-1:0] A,
  output logic              RnW,
  output logic              nAS,
  output logic              nUDS,
  output logic              nLDS,
  output logic [DATA_W-1:0] DOut,
  output logic              DOE,
  input  logic [DATA_W-1:0] DIn,
  input  logic              nDTACK,
  input  logic              nBERR
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  if (TIMEOUT_CYCLES < TIMEOUT_MIN) begin : g_bad_timeout
    $error("fsb_initiator: TIMEOUT_CYCLES below minimum");
  end

  fsb_state_e        state_q, state_d;
  logic              fail_d;
  logic              dtack_s, berr_s;
  logic              accept, accept_bus, accept_null;
  logic              rnw_q;
  logic [1:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_q;
  logic [WD_W-1:0]   wd_cnt;
  logic              ack_q, err_q;
  logic              ds_on;

  fsb_sync #(.RST_VAL(1'b1)) u_sync_dtack (
    .clk (FCLK),
    .rst (Reset),
    .d   (nDTACK),
    .q   (dtack_s)
  );

  fsb_sync #(.RST_VAL(1'b1)) u_sync_berr (
    .clk (FCLK),
    .rst (Reset),
    .d   (nBERR),
    .q   (berr_s)
  );

  assign accept      = (state_q == ST_IDLE) && Req;
  assign accept_bus  = accept && (ReqBE != 2'b00);
  assign accept_null = accept && (ReqBE == 2'b00);

  always_ff @(posedge FCLK) begin
    if (Reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Handshakes are active low after synchronization; bus error outranks DTACK.
  always_comb begin
    state_d = state_q;
    fail_d  = 1'b0;
    case (state_q)
      ST_IDLE:    if (accept_bus) state_d = ST_ADDR;
      ST_ADDR:    state_d = ST_ASSERT;
      ST_ASSERT:  state_d = rnw_q ? ST_WAIT : ST_DSW;
      ST_DSW:     state_d = ST_WAIT;
      ST_WAIT: begin
        if (!berr_s) begin
          state_d = ST_NEGATE;
          fail_d  = 1'b1;
        end else if (!dtack_s) begin
          state_d = ST_DATA;
        end else if (wd_cnt == WD_LAST) begin
          state_d = ST_NEGATE;
          fail_d  = 1'b1;
        end
      end
      ST_DATA:    state_d = ST_NEGATE;
      ST_NEGATE:  state_d = ST_RECOVER;
      ST_RECOVER: if ((dtack_s && berr_s) || (wd_cnt == WD_LAST)) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    nAS   = 1'b1;
    ds_on = 1'b0;
    DOE   = 1'b0;
    RnW   = 1'b1;
    case (state_q)
      ST_ADDR:    RnW = rnw_q;
      ST_ASSERT: begin
        RnW   = rnw_q;
        nAS   = 1'b0;
        ds_on = rnw_q;
        DOE   = !rnw_q;
      end
      ST_DSW, ST_WAIT, ST_DATA: begin
        RnW   = rnw_q;
        nAS   = 1'b0;
        ds_on = 1'b1;
        DOE   = !rnw_q;
      end
      ST_NEGATE: begin
        RnW = rnw_q;
        DOE = !rnw_q;
      end
      default: ;
    endcase
    nUDS = !(ds_on && be_q[1]);
    nLDS = !(ds_on && be_q[0]);
  end

  // Request capture: A and DOut hold the captured values for the whole cycle.
  always_ff @(posedge FCLK) begin
    if (Reset) begin
      rnw_q   <= 1'b1;
      be_q    <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept_bus) begin
      rnw_q   <= ReqRnW;
      be_q    <= ReqBE;
      addr_q  <= ReqAddr;
      wdata_q <= ReqWrData;
    end
  end

  // Watchdog shared by WAIT and RECOVER; cleared on entry to each.
  always_ff @(posedge FCLK) begin
    if (Reset) begin
      wd_cnt <= '0;
    end else if (((state_q != ST_WAIT) && (state_d == ST_WAIT)) || (state_q == ST_NEGATE)) begin
      wd_cnt <= '0;
    end else if ((state_q == ST_WAIT) || (state_q == ST_RECOVER)) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge FCLK) begin
    if (Reset) begin
      rd_q  <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if ((state_q == ST_DATA) && rnw_q) rd_q <= DIn;
      ack_q <= accept_null || (state_d == ST_NEGATE);
      err_q <= accept_null || fail_d;
    end
  end

  assign Busy   = (state_q != ST_IDLE);
  assign Ack    = ack_q;
  assign Err    = err_q;
  assign RdData = rd_q;
  assign A      = addr_q;
  assign DOut   = wdata_q;

endmodule
